// File: rtl/uart_sample_rx.sv
// uart_sample_rx: 8N1 UART receiver that reassembles 4-byte frames
// (0x00, 0x00, {3'b0, s[12:8]}, s[7:0]) into 13-bit samples presented
// through a single-entry valid/ready output register.
module uart_sample_rx #(
    parameter int unsigned UART_CLK_MHZ     = 50,
    parameter int unsigned GAP_TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  baud_sel_i,
    input  logic        rs232_rx_i,
    output logic [12:0] sample_o,
    output logic        sample_valid_o,
    input  logic        sample_ready_i,
    output logic        frame_err_o,
    output logic        proto_err_o,
    output logic        overrun_o
);

    function automatic logic [31:0] calc_div(input logic [31:0] baud);
        return (UART_CLK_MHZ * 32'd1000000 + baud / 32'd2) / baud;
    endfunction

    localparam logic [31:0] DIV_9600   = calc_div(32'd9600);
    localparam logic [31:0] DIV_19200  = calc_div(32'd19200);
    localparam logic [31:0] DIV_38400  = calc_div(32'd38400);
    localparam logic [31:0] DIV_57600  = calc_div(32'd57600);
    localparam logic [31:0] DIV_115200 = calc_div(32'd115200);
    localparam logic [31:0] DIV_230400 = calc_div(32'd230400);
    localparam logic [31:0] DIV_460800 = calc_div(32'd460800);
    localparam logic [31:0] DIV_921600 = calc_div(32'd921600);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} bit_state_t;
    typedef enum logic [1:0] {F_B1, F_B2, F_B3, F_B4} frame_state_t;

    logic         r_sync1, r_sync2, r_sync3;
    bit_state_t   r_bstate;
    logic [31:0]  r_div;
    logic [31:0]  r_baud_cnt;
    logic [2:0]   r_bit_idx;
    logic [7:0]   r_shift;
    logic         r_frame_err;

    frame_state_t r_fstate;
    logic [4:0]   r_hi;
    logic [31:0]  r_gap_cnt;
    logic         r_proto_err;

    logic [12:0]  r_sample;
    logic         r_valid;
    logic         r_overrun;

    logic [31:0]  w_div_sel;
    logic         w_rx;
    logic         w_fall;
    logic         w_tick;
    logic [31:0]  w_half;
    logic         w_stop_sample;
    logic         w_byte_valid;
    logic         w_frame_err;
    logic [31:0]  w_gap_limit;
    logic         w_timeout;
    logic         w_complete;
    logic [12:0]  w_new_sample;

    // Baud divider lookup for the requested rate
    always_comb begin
        w_div_sel = DIV_9600;
        case (baud_sel_i)
            3'd0:    w_div_sel = DIV_9600;
            3'd1:    w_div_sel = DIV_19200;
            3'd2:    w_div_sel = DIV_38400;
            3'd3:    w_div_sel = DIV_57600;
            3'd4:    w_div_sel = DIV_115200;
            3'd5:    w_div_sel = DIV_230400;
            3'd6:    w_div_sel = DIV_460800;
            default: w_div_sel = DIV_921600;
        endcase
    end

    assign w_rx          = r_sync2;
    assign w_fall        = r_sync3 & ~r_sync2;
    assign w_half        = r_div >> 1;
    assign w_tick        = (r_baud_cnt == r_div - 32'd1);
    assign w_stop_sample = (r_bstate == S_STOP) && w_tick;
    assign w_byte_valid  = w_stop_sample & w_rx;
    assign w_frame_err   = w_stop_sample & ~w_rx;

    assign w_gap_limit   = GAP_TIMEOUT_BITS * r_div;
    assign w_timeout     = (r_fstate != F_B1) && (r_gap_cnt >= w_gap_limit);
    assign w_complete    = w_byte_valid && (r_fstate == F_B4);
    assign w_new_sample  = {r_hi, r_shift};

    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= rs232_rx_i;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // Bit-level FSM: start detect, mid-bit sampling, stop check
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bstate    <= S_IDLE;
            r_div       <= '0;
            r_baud_cnt  <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err;
            case (r_bstate)
                S_IDLE: begin
                    r_div      <= w_div_sel;
                    r_baud_cnt <= '0;
                    if (w_fall) r_bstate <= S_START;
                end
                S_START: begin
                    if (r_baud_cnt == w_half) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_bstate   <= w_rx ? S_IDLE : S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 32'd1;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_baud_cnt <= '0;
                        r_shift    <= {w_rx, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) r_bstate <= S_STOP;
                        else r_bit_idx <= r_bit_idx + 3'd1;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 32'd1;
                    end
                end
                default: begin
                    if (w_tick) begin
                        r_baud_cnt <= '0;
                        r_bstate   <= S_IDLE;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 32'd1;
                    end
                end
            endcase
        end
    end

    // Frame FSM and inter-byte gap watchdog; framing error outranks timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fstate    <= F_B1;
            r_hi        <= '0;
            r_gap_cnt   <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_proto_err <= 1'b0;
            if (w_frame_err) begin
                r_fstate  <= F_B1;
                r_gap_cnt <= '0;
            end else if (w_byte_valid) begin
                r_gap_cnt <= '0;
                case (r_fstate)
                    F_B1: begin
                        if (r_shift == 8'h00) r_fstate <= F_B2;
                        else r_proto_err <= 1'b1;
                    end
                    F_B2: begin
                        if (r_shift == 8'h00) r_fstate <= F_B3;
                        else begin
                            r_proto_err <= 1'b1;
                            r_fstate    <= F_B1;
                        end
                    end
                    F_B3: begin
                        if (r_shift[7:5] == 3'b000) begin
                            r_hi     <= r_shift[4:0];
                            r_fstate <= F_B4;
                        end else begin
                            r_proto_err <= 1'b1;
                            r_fstate    <= F_B1;
                        end
                    end
                    default: r_fstate <= F_B1;
                endcase
            end else if (w_timeout) begin
                r_proto_err <= 1'b1;
                r_fstate    <= F_B1;
                r_gap_cnt   <= '0;
            end else if (r_gap_cnt < w_gap_limit) begin
                r_gap_cnt <= r_gap_cnt + 32'd1;
            end
        end
    end

    // Single-entry output register with valid/ready and overrun detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_complete) begin
                if (!r_valid || sample_ready_i) begin
                    r_sample <= w_new_sample;
                    r_valid  <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && sample_ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign sample_o       = r_sample;
    assign sample_valid_o = r_valid;
    assign frame_err_o    = r_frame_err;
    assign proto_err_o    = r_proto_err;
    assign overrun_o      = r_overrun;

endmodule
